// File: rtl/circuit_bist.sv
// circuit_bist: exhaustive self-test engine for the AND3/XNOR3/mux circuit block.
// Sweeps all 128 input combinations, compares out/out_bar against a built-in
// golden model, and reports a saturating mismatch count plus the first failure.
module circuit_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             E,
  output logic             F,
  output logic             sel,
  input  logic             out_in,
  input  logic             out_bar_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [6:0]       first_err_vec
);

  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [6:0]       vec;
  logic [CNT_W-1:0] settle_cnt;
  logic             expected;
  logic             mismatch;
  logic             last_vec;
  logic             settle_end;

  // The vector register is the stimulus: bit order is {sel,A,B,C,D,E,F}.
  assign {sel, A, B, C, D, E, F} = vec;

  // Golden response of the circuit and the per-vector compare result.
  always_comb begin
    expected   = vec[6] ? ~(vec[2] ^ vec[1] ^ vec[0]) : (vec[5] & vec[4] & vec[3]);
    mismatch   = (out_in != expected) || (out_bar_in != ~expected);
    last_vec   = (vec == 7'd127);
    settle_end = (settle_cnt == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status decode.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        busy = 1'b1;
        if (settle_end) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        busy       = 1'b1;
        state_next = last_vec ? DONE : DRIVE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Vector/settle counters and result registers; pass is settled together with
  // the last compare so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec             <= '0;
      settle_cnt      <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec             <= '0;
            settle_cnt      <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
          end
        end
        DRIVE: begin
          if (!settle_end) begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          settle_cnt <= '0;
          if (mismatch) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + 1'b1;
            end
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= vec;
            end
          end
          if (last_vec) begin
            pass <= !(first_err_valid || mismatch);
          end else begin
            vec <= vec + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
